// File: rtl/dram_fifo.sv
// Synchronous FIFO: sync-write / async-read word storage plus a registered valid/ready output stage.
// Define DRAM_FIFO_USAGE_EN to add the registered occupancy output usage_o.
module dram_fifo #(
    parameter int SZ = 4,
    parameter int DW = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                push_i,
    input  logic [DW-1:0]       data_i,
    output logic                full_o,
    input  logic                pop_i,
    output logic                valid_o,
    output logic [DW-1:0]       data_o
`ifdef DRAM_FIFO_USAGE_EN
    ,
    output logic [$clog2(SZ):0] usage_o
`endif
);
    localparam int AW = $clog2(SZ);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [DW-1:0] mem_q [SZ];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          empty;
    logic          push_ok;
    logic          load;

    // Pointer MSB tells a full ring apart from an empty one when the addresses match.
    assign empty   = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push_ok = push_i && !full_o;
    assign load    = (!valid_q || pop_i) && !empty;

    always_comb begin
        // NOTE: every signal gets a default first, so no branch can leave one unassigned and infer a latch.
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        if (push_ok) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (load) begin
            data_d  = mem_q[rptr_q[AW-1:0]];
            valid_d = 1'b1;
            rptr_d  = rptr_q + PTR_ONE;
        end else if (valid_q && pop_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: storage has no reset; the pointers alone decide which words are live.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

`ifdef DRAM_FIFO_USAGE_EN
    logic [PW-1:0] usage_q, usage_d;

    assign usage_d = (wptr_d - rptr_d) + {{AW{1'b0}}, valid_d};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            usage_q <= '0;
        end else begin
            usage_q <= usage_d;
        end
    end

    assign usage_o = usage_q;
`endif

endmodule

// File: tb/tb_dram_fifo.sv
// Self-checking bench for dram_fifo (SZ=4, DW=32): vector table, corner sequences, random traffic vs a queue model.
// usage_o is only connected and checked when DRAM_FIFO_USAGE_EN is defined.
module tb_dram_fifo;
    localparam int SZ = 4;
    localparam int DW = 32;
    localparam int PW = $clog2(SZ) + 1;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic          push_i;
    logic [DW-1:0] data_i;
    logic          full_o;
    logic          pop_i;
    logic          valid_o;
    logic [DW-1:0] data_o;
`ifdef DRAM_FIFO_USAGE_EN
    logic [PW-1:0] usage_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: storage as a queue plus the output register.
    logic [DW-1:0] m_store[$];
    logic          m_valid;
    logic [DW-1:0] m_data;

    always #5 clk_i = ~clk_i;

    dram_fifo #(.SZ(SZ), .DW(DW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push_i),
        .data_i  (data_i),
        .full_o  (full_o),
        .pop_i   (pop_i),
        .valid_o (valid_o),
        .data_o  (data_o)
`ifdef DRAM_FIFO_USAGE_EN
        ,
        .usage_o (usage_o)
`endif
    );

    typedef struct {
        logic          push;
        logic [DW-1:0] din;
        logic          pop;
        logic          valid;
        logic [DW-1:0] dout;
        logic          full;
        int            usage;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_usage(input string name, input int exp);
`ifdef DRAM_FIFO_USAGE_EN
        check(name, 32'(usage_o), 32'(exp));
`endif
    endtask

    function automatic void model_clear();
        m_store.delete();
        m_valid = 1'b0;
        m_data  = '0;
    endfunction

    // One clock edge of the FIFO rules: full and the load decision use pre-edge state.
    function automatic void model_edge(input logic p, input logic [DW-1:0] d, input logic q);
        bit was_full;
        was_full = (m_store.size() == SZ);
        if ((!m_valid || q) && m_store.size() > 0) begin
            m_data  = m_store.pop_front();
            m_valid = 1'b1;
        end else if (m_valid && q) begin
            m_valid = 1'b0;
        end
        if (p && !was_full) m_store.push_back(d);
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".valid"}, 32'(valid_o), 32'(m_valid));
        check({tag, ".data"},  data_o, m_data);
        check({tag, ".full"},  32'(full_o), 32'(m_store.size() == SZ));
        check_usage({tag, ".usage"}, m_store.size() + int'(m_valid));
    endtask

    // Entered and left at a falling edge; inputs change away from the rising edge.
    task automatic cycle(input logic p, input logic [DW-1:0] d, input logic q);
        push_i = p;
        data_i = d;
        pop_i  = q;
        @(posedge clk_i);
        model_edge(p, d, q);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        push_i  = 1'b0;
        pop_i   = 1'b0;
        data_i  = '0;
        rst_n_i = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          vecs[11];
        logic [DW-1:0] got[$];
        bit            saw_full;
        int            bias;

        // Tests 2 and 3: fill with 0x1..0x6 (0x6 dropped), then drain with pop held.
        vecs[0]  = '{1'b1, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 1};
        vecs[1]  = '{1'b1, 32'h2, 1'b0, 1'b1, 32'h1, 1'b0, 2};
        vecs[2]  = '{1'b1, 32'h3, 1'b0, 1'b1, 32'h1, 1'b0, 3};
        vecs[3]  = '{1'b1, 32'h4, 1'b0, 1'b1, 32'h1, 1'b0, 4};
        vecs[4]  = '{1'b1, 32'h5, 1'b0, 1'b1, 32'h1, 1'b1, 5};
        vecs[5]  = '{1'b1, 32'h6, 1'b0, 1'b1, 32'h1, 1'b1, 5};
        vecs[6]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h2, 1'b0, 4};
        vecs[7]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h3, 1'b0, 3};
        vecs[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h4, 1'b0, 2};
        vecs[9]  = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h5, 1'b0, 1};
        vecs[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h5, 1'b0, 0};

        // Test 1: reset state and first-word latency.
        do_reset();
        check("rst.valid", 32'(valid_o), 32'h0);
        check("rst.data",  data_o, 32'h0);
        check("rst.full",  32'(full_o), 32'h0);
        check_usage("rst.usage", 0);
        cycle(1'b1, 32'hA, 1'b0);
        check("t1.edge1.valid", 32'(valid_o), 32'h0);
        cycle(1'b0, 32'h0, 1'b0);
        check("t1.edge2.valid", 32'(valid_o), 32'h1);
        check("t1.edge2.data",  data_o, 32'hA);
        check("t1.edge2.full",  32'(full_o), 32'h0);
        check_usage("t1.edge2.usage", 1);

        // Tests 2 and 3 from the table.
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].push, vecs[i].din, vecs[i].pop);
            check($sformatf("vec%0d.valid", i), 32'(valid_o), 32'(vecs[i].valid));
            check($sformatf("vec%0d.data", i),  data_o, vecs[i].dout);
            check($sformatf("vec%0d.full", i),  32'(full_o), 32'(vecs[i].full));
            check_usage($sformatf("vec%0d.usage", i), vecs[i].usage);
        end

        // Test 4: streaming 0..19 with pop held; pointers wrap several times.
        do_reset();
        saw_full = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (valid_o) got.push_back(data_o);
            cycle(1'b1, DW'(i), 1'b1);
            check_model($sformatf("t4.c%0d", i));
            if (full_o) saw_full = 1'b1;
        end
        for (int i = 0; i < 6 && got.size() < 20; i++) begin
            if (valid_o) got.push_back(data_o);
            cycle(1'b0, '0, 1'b1);
        end
        check("t4.count", 32'(got.size()), 32'd20);
        check("t4.full_seen", 32'(saw_full), 32'h0);
        for (int i = 0; i < 20 && i < got.size(); i++) begin
            if (got[i] !== DW'(i)) check($sformatf("t4.order%0d", i), got[i], DW'(i));
        end

        // Test 5: push while full with a pop in the same cycle is still dropped.
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i), 1'b0);
        check("t5.full_before", 32'(full_o), 32'h1);
        cycle(1'b1, 32'h77, 1'b1);
        check("t5.full_after", 32'(full_o), 32'h0);
        check("t5.head", data_o, 32'h2);
        check_usage("t5.usage", 4);
        for (int i = 3; i <= 5; i++) begin
            cycle(1'b0, '0, 1'b1);
            check($sformatf("t5.drain%0d", i), data_o, DW'(i));
        end
        cycle(1'b0, '0, 1'b1);
        check("t5.empty.valid", 32'(valid_o), 32'h0);

        // Test 6: asynchronous reset mid-stream while full, then test 1 again.
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, DW'(i + 16), 1'b0);
        check("t6.full_before", 32'(full_o), 32'h1);
        #2;
        rst_n_i = 1'b0;
        #1;
        model_clear();
        check("t6.async.valid", 32'(valid_o), 32'h0);
        check("t6.async.full",  32'(full_o), 32'h0);
        check_usage("t6.async.usage", 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cycle(1'b1, 32'hA, 1'b0);
        check("t6.edge1.valid", 32'(valid_o), 32'h0);
        cycle(1'b0, 32'h0, 1'b0);
        check("t6.edge2.valid", 32'(valid_o), 32'h1);
        check("t6.edge2.data",  data_o, 32'hA);
        check_usage("t6.edge2.usage", 1);

        // Random traffic: a push-heavy phase, then a pop-heavy phase.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            bias = (i < 200) ? 75 : 30;
            cycle($urandom_range(99) < bias, $urandom, $urandom_range(99) >= bias);
            check_model($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
